poly_fire_sched: RTL

//  Firing scheduler for the polynomial-evaluation actor. It checks the command, data,

---
 rtl/poly_fire_sched_pkg.sv | 42 ++++
 rtl/poly_cmd_decode.sv | 50 +++++
 rtl/poly_fire_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/poly_fire_sched_pkg.sv
// Shared definitions for the polynomial-evaluation actor firing scheduler:
// opcode encodings, command-word field positions, scheduler states and a
// ceiling-log2 helper used to size the population and count ports.
package poly_fire_sched_pkg;

  typedef enum logic [1:0] {
    OP_STORE = 2'd0,
    OP_EVAL  = 2'd1,
    OP_RST   = 2'd2,
    OP_BAD   = 2'd3
  } op_t;

  // Command word layout: [1:0] opcode, [15:8] STORE token count minus one.
  localparam int unsigned CMD_OP_LSB = 0;
  localparam int unsigned CMD_OP_MSB = 1;
  localparam int unsigned CMD_N_LSB  = 8;
  localparam int unsigned CMD_N_MSB  = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_REQ,
    S_CMD_WAIT,
    S_DECODE,
    S_DATA_CHK,
    S_DATA_REQ,
    S_DATA_WAIT,
    S_SPACE_CHK,
    S_EXEC,
    S_EXEC_WAIT
  } state_t;

  // Ceiling log2; log2(1024) = 10, log2(16) = 4.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/poly_cmd_decode.sv
// Combinational command decoder, shared with the datapath.
// Ports:
//   cmd_word  in   command token
//   op        out  decoded opcode (OP_BAD for illegal opcode or oversized STORE)
//   n         out  data tokens required by the command (0 when in error)
//   err       out  command is illegal
module poly_cmd_decode
  import poly_fire_sched_pkg::*;
#(
  parameter int unsigned word_size = 16,
  parameter int unsigned max_data  = 16
) (
  input  logic [word_size-1:0]     cmd_word,
  output op_t                      op,
  output logic [log2(max_data):0]  n,
  output logic                     err
);

  localparam int unsigned CW   = log2(max_data) + 1;
  localparam int unsigned NF_W = CMD_N_MSB - CMD_N_LSB + 2;

  logic [NF_W-1:0] n_full;
  op_t             raw_op;
  logic            unused_bits;

  assign unused_bits = ^cmd_word[CMD_N_LSB-1:CMD_OP_MSB+1];

  always_comb begin
    raw_op = op_t'(cmd_word[CMD_OP_MSB:CMD_OP_LSB]);
    // One extra bit so a field of all ones (256 tokens) does not wrap to 0.
    n_full = NF_W'(cmd_word[CMD_N_MSB:CMD_N_LSB]) + NF_W'(1);
    op     = raw_op;
    n      = '0;
    err    = 1'b0;
    case (raw_op)
      OP_STORE: begin
        if (32'(n_full) > max_data) begin
          err = 1'b1;
          op  = OP_BAD;
        end else begin
          n = CW'(n_full);
        end
      end
      OP_EVAL: n = CW'(1);
      OP_RST:  n = '0;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/poly_fire_sched.sv
// Firing scheduler for the polynomial-evaluation actor. Moves one command
// token, decodes it, moves the required data tokens one at a time, checks
// output space and then issues a single execute request to the datapath.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   *_population/space    FIFO occupancy / free-space inputs (PW bits)
//   cmd_word              command token, valid with cmd_move_done
//   cmd/data_move_done    mem_controller move-complete pulses
//   exec_done             datapath firing-complete pulse
//   cmd/data_move_start   single-token move requests (pulses)
//   exec_start, ram_clr   firing start, RAM address clear on RST (pulses)
//   exec_op, exec_count   decoded opcode and loaded token count
//   busy, cmd_error       scheduler active, illegal command seen
module poly_fire_sched
  import poly_fire_sched_pkg::*;
#(
  parameter int unsigned word_size   = 16,
  parameter int unsigned buffer_size = 1024,
  parameter int unsigned max_data    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [log2(buffer_size):0]  command_population,
  input  logic [log2(buffer_size):0]  data_population,
  input  logic [log2(buffer_size):0]  result_free_space,
  input  logic [log2(buffer_size):0]  status_free_space,
  input  logic [word_size-1:0]        cmd_word,
  input  logic                        cmd_move_done,
  input  logic                        data_move_done,
  input  logic                        exec_done,
  output logic                        cmd_move_start,
  output logic                        data_move_start,
  output logic                        exec_start,
  output logic [1:0]                  exec_op,
  output logic [log2(max_data):0]     exec_count,
  output logic                        ram_clr,
  output logic                        busy,
  output logic                        cmd_error
);

  localparam int unsigned CW = log2(max_data) + 1;

  state_t               state, state_n;
  logic [word_size-1:0] cmd_q, cmd_q_n;
  logic [CW-1:0]        n_q, n_n;
  logic [CW-1:0]        loaded, loaded_n, loaded_inc;
  logic [CW-1:0]        count_n;
  op_t                  op_n;
  logic                 err_n;

  op_t                  dec_op;
  logic [CW-1:0]        dec_n;
  logic                 dec_err;

  poly_cmd_decode #(
    .word_size (word_size),
    .max_data  (max_data)
  ) u_decode (
    .cmd_word (cmd_q),
    .op       (dec_op),
    .n        (dec_n),
    .err      (dec_err)
  );

  assign loaded_inc = loaded + CW'(1);

  always_comb begin
    state_n  = state;
    cmd_q_n  = cmd_q;
    op_n     = op_t'(exec_op);
    n_n      = n_q;
    err_n    = cmd_error;
    loaded_n = loaded;
    count_n  = exec_count;
    case (state)
      S_IDLE:     if (command_population != '0) state_n = S_CMD_REQ;
      S_CMD_REQ:  state_n = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (cmd_move_done) begin
          cmd_q_n = cmd_word;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        op_n    = dec_op;
        n_n     = dec_n;
        err_n   = dec_err;
        state_n = (dec_n == '0) ? S_SPACE_CHK : S_DATA_CHK;
      end
      // All remaining tokens must already be present; starting a partial
      // load could leave the scheduler waiting on a producer that is itself
      // blocked behind this firing.
      S_DATA_CHK: begin
        if (32'(data_population) >= 32'(n_q - loaded)) state_n = S_DATA_REQ;
      end
      S_DATA_REQ: state_n = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (data_move_done) begin
          loaded_n = loaded_inc;
          state_n  = (loaded_inc == n_q) ? S_SPACE_CHK : S_DATA_REQ;
        end
      end
      S_SPACE_CHK: begin
        if (status_free_space != '0 &&
            (exec_op != OP_EVAL || result_free_space != '0)) begin
          count_n = loaded;
          state_n = S_EXEC;
        end
      end
      S_EXEC: state_n = S_EXEC_WAIT;
      S_EXEC_WAIT: begin
        if (exec_done) begin
          err_n    = 1'b0;
          loaded_n = '0;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pulse outputs are registered from the next state so each pulse is
  // asserted for exactly the cycle spent in its request state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cmd_q           <= '0;
      n_q             <= '0;
      loaded          <= '0;
      exec_op         <= '0;
      exec_count      <= '0;
      cmd_error       <= 1'b0;
      cmd_move_start  <= 1'b0;
      data_move_start <= 1'b0;
      exec_start      <= 1'b0;
      ram_clr         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      cmd_q           <= cmd_q_n;
      n_q             <= n_n;
      loaded          <= loaded_n;
      exec_op         <= op_n;
      exec_count      <= count_n;
      cmd_error       <= err_n;
      cmd_move_start  <= (state_n == S_CMD_REQ);
      data_move_start <= (state_n == S_DATA_REQ);
      exec_start      <= (state_n == S_EXEC);
      ram_clr         <= (state_n == S_EXEC) && (op_n == OP_RST);
      busy            <= (state_n != S_IDLE);
    end
  end

endmodule
